// File: rtl/button_event_arbiter.sv
// Debounced-by-sampling button press detector feeding a round-robin event arbiter.
// One event per press; a press that lands on a still-pending button is flagged as overflow.
module button_event_arbiter #(
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned N_BTN    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    input  logic             ack,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [1:0]       evt_id,
    output logic [N_BTN-1:0] pending,
    output logic [N_BTN-1:0] overflow
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_EDGE = 2'd1,
        P_HELD = 2'd2
    } press_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_t;

    logic [CW-1:0]      r_tick_cnt;
    logic               w_tick;
    logic [N_BTN-1:0]   r_sync1;
    logic [N_BTN-1:0]   r_sync2;
    press_t             r_press     [N_BTN];
    press_t             w_press_nxt [N_BTN];
    logic [N_BTN-1:0]   w_edge;

    arb_t               r_arb;
    arb_t               w_arb_nxt;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         w_rr_nxt;
    logic               r_evt_valid;
    logic               w_valid_nxt;
    logic [1:0]         r_evt_id;
    logic [1:0]         w_id_nxt;
    logic [N_BTN-1:0]   r_pending;
    logic [N_BTN-1:0]   w_pend_nxt;
    logic [N_BTN-1:0]   r_overflow;
    logic [N_BTN-1:0]   w_ovf_nxt;
    logic [N_BTN-1:0]   w_ack_clr;

    logic [2*N_BTN-1:0] w_rot;
    logic [1:0]         w_off;
    logic               w_found;
    logic [1:0]         w_sel;

    assign w_tick = (r_tick_cnt == CW'(TICK_DIV - 1));

    always_comb begin
        w_edge = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            w_press_nxt[i] = r_press[i];
            if (w_tick) begin
                if (!r_sync2[i]) begin
                    w_press_nxt[i] = P_IDLE;
                end else begin
                    case (r_press[i])
                        P_IDLE: begin
                            w_press_nxt[i] = P_EDGE;
                            w_edge[i]      = 1'b1;
                        end
                        P_EDGE, P_HELD: w_press_nxt[i] = P_HELD;
                        default:        w_press_nxt[i] = P_IDLE;
                    endcase
                end
            end
        end
    end

    // Rotate pending so the search always starts at bit 0, then map back by adding rr_ptr.
    always_comb begin
        w_rot   = {r_pending, r_pending} >> r_rr_ptr;
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 2'(k);
            end
        end
        w_sel = r_rr_ptr + w_off;
    end

    always_comb begin
        w_arb_nxt   = r_arb;
        w_valid_nxt = r_evt_valid;
        w_id_nxt    = r_evt_id;
        w_rr_nxt    = r_rr_ptr;
        w_ack_clr   = '0;
        case (r_arb)
            ARB_IDLE: begin
                if (|r_pending) begin
                    w_id_nxt    = w_sel;
                    w_valid_nxt = 1'b1;
                    w_arb_nxt   = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (ack) begin
                    w_ack_clr[r_evt_id] = 1'b1;
                    w_rr_nxt            = r_evt_id + 2'd1;
                    w_valid_nxt         = 1'b0;
                    w_arb_nxt           = ARB_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_arb_nxt   = ARB_IDLE;
            end
        endcase
        // A fresh edge re-arms a bit being acked on the same cycle without counting as lost.
        w_pend_nxt = (r_pending & ~w_ack_clr) | w_edge;
        w_ovf_nxt  = (clr_ovf ? '0 : r_overflow) | (w_edge & r_pending & ~w_ack_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_press[i] <= P_IDLE;
            end
            r_arb       <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_pending   <= '0;
            r_overflow  <= '0;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + CW'(1);
            r_sync1     <= btn;
            r_sync2     <= r_sync1;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_press[i] <= w_press_nxt[i];
            end
            r_arb       <= w_arb_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_evt_valid <= w_valid_nxt;
            r_evt_id    <= w_id_nxt;
            r_pending   <= w_pend_nxt;
            r_overflow  <= w_ovf_nxt;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter at TICK_DIV=4: press-pattern table
// with a scoreboard of expected event IDs, plus directed multi-cycle corner cases.
module tb_button_event_arbiter;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] btn     = '0;
    logic       ack     = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic [3:0] overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cnt   = 0;
    logic [1:0] exp_q [$];

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] ids;
    } vec_t;

    vec_t vec [6];

    button_event_arbiter #(.TICK_DIV(4), .N_BTN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .ack       (ack),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Independent model of the sample-tick phase: the edge leaving count 3 is a tick edge.
    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_evt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve_one(input string tag, input bit chk_p, input logic [3:0] exp_p);
        bit ok;
        logic [1:0] e;
        wait_evt(ok);
        if (!ok) begin
            chk({tag, "_evt_seen"}, {31'd0, evt_valid}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_evt"}, exp_q.size(), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_evt_id"}, {30'd0, evt_id}, {30'd0, e});
        if (chk_p) chk({tag, "_pending_at_evt"}, {28'd0, pending}, {28'd0, exp_p});
        @(negedge clk);
        chk({tag, "_hold_valid"}, {31'd0, evt_valid}, 32'd1);
        chk({tag, "_hold_id"}, {30'd0, evt_id}, {30'd0, e});
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({tag, "_gap"}, {31'd0, evt_valid}, 32'd0);
    endtask

    task automatic count_events(input int cycles, output int extra);
        extra = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (evt_valid) extra++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int extra;
        int viol;
        logic [1:0] e;

        vec[0] = '{mask: 4'b1111, n: 3'd4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
        vec[1] = '{mask: 4'b0001, n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
        vec[2] = '{mask: 4'b0100, n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
        vec[3] = '{mask: 4'b0101, n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};
        vec[4] = '{mask: 4'b1010, n: 3'd2, ids: {2'd0, 2'd0, 2'd1, 2'd3}};
        vec[5] = '{mask: 4'b0110, n: 3'd2, ids: {2'd0, 2'd0, 2'd1, 2'd2}};

        repeat (3) @(negedge clk);
        chk("rst_valid",    {31'd0, evt_valid}, 32'd0);
        chk("rst_id",       {30'd0, evt_id},    32'd0);
        chk("rst_pending",  {28'd0, pending},   32'd0);
        chk("rst_overflow", {28'd0, overflow},  32'd0);
        reset = 1'b0;

        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_ignored", {31'd0, evt_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // Pointer history: 0 -> 0 -> 1 -> 3 -> 3 -> 2 -> 2 across the table.
        for (int r = 0; r < 6; r++) begin
            btn = vec[r].mask;
            for (int k = 0; k < int'(vec[r].n); k++) exp_q.push_back(vec[r].ids[k]);
            for (int k = 0; k < int'(vec[r].n); k++)
                serve_one($sformatf("vec%0d", r), k == 0, vec[r].mask);
            count_events(20, extra);
            chk($sformatf("vec%0d_no_extra", r), extra, 32'd0);
            chk($sformatf("vec%0d_pending_clear", r), {28'd0, pending}, 32'd0);
            chk($sformatf("vec%0d_no_overflow", r), {28'd0, overflow}, 32'd0);
            btn = '0;
            repeat (12) @(negedge clk);
        end

        btn = 4'b0010;
        exp_q.push_back(2'd1);
        wait_evt(ok);
        if (!ok) chk("ovf_evt_seen", {31'd0, evt_valid}, 32'd1);
        else begin
            e = exp_q.pop_front();
            chk("ovf_evt_id", {30'd0, evt_id}, {30'd0, e});
        end
        btn = '0;
        repeat (16) @(negedge clk);
        btn = 4'b0010;
        repeat (16) @(negedge clk);
        chk("ovf_overflow", {28'd0, overflow}, 32'h2);
        chk("ovf_pending",  {28'd0, pending},  32'h2);
        chk("ovf_valid",    {31'd0, evt_valid}, 32'd1);
        chk("ovf_id",       {30'd0, evt_id},   32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared",      {28'd0, overflow}, 32'd0);
        chk("ovf_pending_kept", {28'd0, pending},  32'h2);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ovf_ack_valid",   {31'd0, evt_valid}, 32'd0);
        chk("ovf_ack_pending", {28'd0, pending},   32'd0);
        btn = '0;
        repeat (12) @(negedge clk);

        btn = 4'b1000;
        exp_q.push_back(2'd3);
        wait_evt(ok);
        if (!ok) chk("same_evt_seen", {31'd0, evt_valid}, 32'd1);
        else begin
            e = exp_q.pop_front();
            chk("same_evt_id", {30'd0, evt_id}, {30'd0, e});
        end
        btn = '0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 8 && tb_cnt != 1; i++) @(negedge clk);
        btn = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("same_still_granted", {31'd0, evt_valid}, 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("same_pending3",  {31'd0, pending[3]},  32'd1);
        chk("same_overflow3", {31'd0, overflow[3]}, 32'd0);
        chk("same_gap",       {31'd0, evt_valid},   32'd0);
        exp_q.push_back(2'd3);
        serve_one("same_reissue", 1'b1, 4'b1000);
        chk("same_pending_clear", {28'd0, pending},  32'd0);
        chk("same_no_overflow",   {28'd0, overflow}, 32'd0);
        btn = '0;
        repeat (12) @(negedge clk);

        btn = 4'b0110;
        exp_q.push_back(2'd1);
        wait_evt(ok);
        if (!ok) chk("rstg_evt_seen", {31'd0, evt_valid}, 32'd1);
        else begin
            e = exp_q.pop_front();
            chk("rstg_evt_id", {30'd0, evt_id}, {30'd0, e});
        end
        chk("rstg_pending_before", {28'd0, pending}, 32'h6);
        reset = 1'b1;
        btn   = '0;
        @(negedge clk);
        reset = 1'b0;
        chk("rstg_valid",    {31'd0, evt_valid}, 32'd0);
        chk("rstg_pending",  {28'd0, pending},   32'd0);
        chk("rstg_overflow", {28'd0, overflow},  32'd0);
        count_events(40, extra);
        chk("rstg_no_event", extra, 32'd0);

        reset = 1'b1;
        btn   = 4'b0001;
        viol  = 0;
        repeat (12) begin
            @(negedge clk);
            if (pending != 4'b0000 || evt_valid) viol++;
        end
        chk("rst_held_no_events", viol, 32'd0);
        reset = 1'b0;
        exp_q.push_back(2'd0);
        serve_one("held_after_reset", 1'b1, 4'b0001);
        count_events(20, extra);
        chk("held_after_reset_no_extra", extra, 32'd0);
        btn = '0;
        repeat (8) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
